la_readout_sequencer: RTL and testbench

LA_READOUT_SEQUENCER -- requirements
Module: la_readout_sequencer

---
 rtl/la_readout_sequencer.sv | 119 +++++++++++
 tb/tb_la_readout_sequencer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/la_readout_sequencer.sv
// Logic-analyzer readout sequencer: arms the analyzer, then streams every
// captured sample out MSB word first over a valid/ready host interface.
module la_readout_sequencer #(
  parameter int DEPTH        = 512,
  parameter int ADDR_WIDTH   = 9,
  parameter int SAMPLE_WIDTH = 128,
  parameter int WORD_WIDTH   = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_arm,
  input  logic                    cmd_abort,
  output logic                    la_arm,
  input  logic                    la_capture_done,
  output logic [ADDR_WIDTH-1:0]   la_read_addr,
  input  logic [SAMPLE_WIDTH-1:0] la_read_data,
  output logic [WORD_WIDTH-1:0]   out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last,
  output logic                    busy
);

  localparam int WPS = SAMPLE_WIDTH / WORD_WIDTH;
  localparam int WCW = (WPS > 1) ? $clog2(WPS) : 1;
  localparam logic [WCW-1:0]        LAST_WORD  = WCW'(WPS - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_INDEX = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [2:0] {IDLE, ARMED, FETCH, LOAD, SEND, DONE} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   index_q, index_d;
  logic [WCW-1:0]          word_q, word_d;
  logic [SAMPLE_WIDTH-1:0] shift_q, shift_d;
  logic [ADDR_WIDTH-1:0]   la_read_addr_q, la_read_addr_d;
  logic                    arm_hold_q, arm_hold_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      index_q        <= '0;
      word_q         <= '0;
      shift_q        <= '0;
      la_read_addr_q <= '0;
      arm_hold_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      index_q        <= index_d;
      word_q         <= word_d;
      shift_q        <= shift_d;
      la_read_addr_q <= la_read_addr_d;
      arm_hold_q     <= arm_hold_d;
    end
  end

  // arm_hold masks a stale capture_done during the first ARMED cycle
  always_comb begin
    state_d        = state_q;
    index_d        = index_q;
    word_d         = word_q;
    shift_d        = shift_q;
    arm_hold_d     = arm_hold_q;
    la_read_addr_d = la_read_addr_q;
    case (state_q)
      IDLE: begin
        if (cmd_arm && !cmd_abort) begin
          state_d    = ARMED;
          arm_hold_d = 1'b1;
        end
      end
      ARMED: begin
        if (arm_hold_q) begin
          arm_hold_d = 1'b0;
        end else if (la_capture_done) begin
          state_d = FETCH;
          index_d = '0;
        end
      end
      FETCH: state_d = LOAD;
      LOAD: begin
        shift_d = la_read_data;
        word_d  = '0;
        state_d = SEND;
      end
      SEND: begin
        if (out_ready) begin
          shift_d = shift_q << WORD_WIDTH;
          word_d  = word_q + WCW'(1);
          if (word_q == LAST_WORD) begin
            if (index_q != LAST_INDEX) begin
              index_d = index_q + ADDR_WIDTH'(1);
              state_d = FETCH;
            end else begin
              state_d = DONE;
            end
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (cmd_abort && (state_q != IDLE)) begin
      state_d    = IDLE;
      index_d    = '0;
      word_d     = '0;
      arm_hold_d = 1'b0;
    end
    // Address register follows the next index so it is already valid in FETCH
    la_read_addr_d = index_d;
  end

  assign la_arm       = (state_q == ARMED);
  assign busy         = (state_q != IDLE);
  assign out_valid    = (state_q == SEND);
  assign out_last     = out_valid && (index_q == LAST_INDEX) && (word_q == LAST_WORD);
  assign out_data     = out_valid ? shift_q[SAMPLE_WIDTH-1 -: WORD_WIDTH] : '0;
  assign la_read_addr = la_read_addr_q;

endmodule

// File: tb/tb_la_readout_sequencer.sv
// Self-checking bench for la_readout_sequencer: a vector table for the
// control corners plus randomized runs against a word-list reference model.
module tb_la_readout_sequencer;

  localparam int DEPTH        = 4;
  localparam int ADDR_WIDTH   = 2;
  localparam int SAMPLE_WIDTH = 128;
  localparam int WORD_WIDTH   = 32;
  localparam int WPS          = SAMPLE_WIDTH / WORD_WIDTH;
  localparam int TOTAL        = DEPTH * WPS;

  logic                    clk;
  logic                    rst_n;
  logic                    cmd_arm;
  logic                    cmd_abort;
  logic                    la_arm;
  logic                    la_capture_done;
  logic [ADDR_WIDTH-1:0]   la_read_addr;
  logic [SAMPLE_WIDTH-1:0] la_read_data;
  logic [WORD_WIDTH-1:0]   out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic                    out_last;
  logic                    busy;

  int checks   = 0;
  int failures = 0;

  logic [WORD_WIDTH-1:0] mem_words [DEPTH][WPS];

  la_readout_sequencer #(
    .DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH),
    .SAMPLE_WIDTH(SAMPLE_WIDTH), .WORD_WIDTH(WORD_WIDTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cmd_arm(cmd_arm), .cmd_abort(cmd_abort),
    .la_arm(la_arm), .la_capture_done(la_capture_done),
    .la_read_addr(la_read_addr), .la_read_data(la_read_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word 0 of each sample sits in the most-significant slot
  function automatic logic [SAMPLE_WIDTH-1:0] pack_sample(input int k);
    logic [SAMPLE_WIDTH-1:0] s;
    s = '0;
    for (int w = 0; w < WPS; w++)
      s = (s << WORD_WIDTH) | SAMPLE_WIDTH'(mem_words[k][w]);
    return s;
  endfunction

  // Analyzer memory model with one cycle of read latency
  always @(posedge clk) la_read_data <= pack_sample(int'(la_read_addr));

  typedef struct {
    logic arm, abort, done, ready;
    logic exp_la_arm, exp_busy, exp_valid;
    logic [ADDR_WIDTH-1:0] exp_addr;
  } vec_t;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_output(input string name, input logic [127:0] actual,
                              input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input vec_t v);
    cmd_arm         = v.arm;
    cmd_abort       = v.abort;
    la_capture_done = v.done;
    out_ready       = v.ready;
  endtask

  task automatic run_capture(input int mode, input int abort_at, input int reset_at);
    logic [WORD_WIDTH-1:0] exp_words[$];
    int xfers, last_seen, cyc, last_cyc;
    logic prev_stalled, prev_last;
    logic [WORD_WIDTH-1:0] prev_data;
    bit finished;
    xfers = 0; last_seen = 0; cyc = 0; last_cyc = 0;
    prev_stalled = 1'b0; prev_last = 1'b0; prev_data = '0; finished = 1'b0;
    for (int k = 0; k < DEPTH; k++)
      for (int w = 0; w < WPS; w++) begin
        case (mode)
          0:       mem_words[k][w] = 32'(k + w);
          1:       mem_words[k][w] = 32'(16 * k + w + 'h100);
          default: mem_words[k][w] = $urandom;
        endcase
        exp_words.push_back(mem_words[k][w]);
      end
    cmd_arm = 1'b1;
    step();
    cmd_arm = 1'b0;
    check_output("arm_la_arm", la_arm, 1);
    repeat (4) step();
    la_capture_done = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      if (abort_at >= 0 && xfers == abort_at) begin
        out_ready = 1'b0;
        cmd_abort = 1'b1;
        step();
        cmd_abort = 1'b0;
        check_output("abort_valid", out_valid, 0);
        check_output("abort_busy", busy, 0);
        check_output("abort_la_arm", la_arm, 0);
        check_output("abort_no_last", last_seen, 0);
        return;
      end
      if (reset_at >= 0 && xfers == reset_at) begin
        #2 rst_n = 1'b0;
        #1;
        check_output("rst_la_arm", la_arm, 0);
        check_output("rst_addr", la_read_addr, 0);
        check_output("rst_valid", out_valid, 0);
        check_output("rst_last", out_last, 0);
        check_output("rst_data", out_data, 0);
        check_output("rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        la_capture_done = 1'b1;
        out_ready = 1'b1;
        repeat (8) begin
          step();
          check_output("rst_no_restart", busy, 0);
        end
        la_capture_done = 1'b0;
        return;
      end
      if (la_capture_done && !la_arm) la_capture_done = 1'b0;
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (prev_stalled) begin
        check_output("stall_valid", out_valid, 1);
        check_output("stall_data", out_data, prev_data);
        check_output("stall_last", out_last, prev_last);
      end
      if (out_valid) begin
        check_output("last_flag", out_last, (xfers == TOTAL - 1));
        if (out_ready) begin
          if (xfers < TOTAL) check_output("word_data", out_data, exp_words[xfers]);
          else check_output("extra_word", xfers, TOTAL - 1);
          if (out_last) last_seen++;
          last_cyc = cyc;
          xfers++;
        end
      end
      prev_stalled = out_valid && !out_ready;
      prev_data    = out_data;
      prev_last    = out_last;
      step();
      cyc++;
      if (!busy) begin
        finished = 1'b1;
        break;
      end
    end
    out_ready = 1'b0;
    la_capture_done = 1'b0;
    if (!finished) begin
      check_output("run_timeout", 0, 1);
    end else begin
      check_output("xfer_count", xfers, TOTAL);
      check_output("last_count", last_seen, 1);
      check_output("busy_drop_delay", cyc - last_cyc, 2);
    end
  endtask

  vec_t vecs[11];

  initial begin
    // arm, abort, done, ready -> la_arm, busy, valid, addr
    vecs[0]  = '{1, 0, 0, 0, 1, 1, 0, 0};
    vecs[1]  = '{1, 1, 0, 0, 0, 0, 0, 0};
    vecs[2]  = '{1, 1, 1, 0, 0, 0, 0, 0};
    vecs[3]  = '{1, 0, 1, 0, 1, 1, 0, 0};
    vecs[4]  = '{0, 0, 1, 0, 1, 1, 0, 0};
    vecs[5]  = '{0, 0, 1, 0, 0, 1, 0, 0};
    vecs[6]  = '{0, 0, 0, 0, 0, 1, 0, 0};
    vecs[7]  = '{1, 0, 0, 0, 0, 1, 1, 0};
    vecs[8]  = '{0, 0, 0, 0, 0, 1, 1, 0};
    vecs[9]  = '{0, 1, 0, 0, 0, 0, 0, 0};
    vecs[10] = '{0, 0, 0, 0, 0, 0, 0, 0};

    for (int k = 0; k < DEPTH; k++)
      for (int w = 0; w < WPS; w++) mem_words[k][w] = 32'(k + w);
    rst_n = 1'b0;
    cmd_arm = 1'b0; cmd_abort = 1'b0; la_capture_done = 1'b0; out_ready = 1'b0;
    repeat (3) step();
    check_output("reset_la_arm", la_arm, 0);
    check_output("reset_addr", la_read_addr, 0);
    check_output("reset_valid", out_valid, 0);
    check_output("reset_last", out_last, 0);
    check_output("reset_data", out_data, 0);
    check_output("reset_busy", busy, 0);

    rst_n = 1'b1;
    for (int i = 0; i < 11; i++) begin
      apply_stimulus(vecs[i]);
      step();
      check_output($sformatf("vec%0d_la_arm", i), la_arm, vecs[i].exp_la_arm);
      check_output($sformatf("vec%0d_busy", i), busy, vecs[i].exp_busy);
      check_output($sformatf("vec%0d_valid", i), out_valid, vecs[i].exp_valid);
      check_output($sformatf("vec%0d_addr", i), la_read_addr, vecs[i].exp_addr);
    end
    apply_stimulus(vecs[10]);

    run_capture(0, -1, -1);
    run_capture(1, -1, -1);
    run_capture(2, -1, -1);
    run_capture(0, 6, -1);
    run_capture(0, -1, -1);
    run_capture(2, -1, 5);
    run_capture(1, -1, -1);
    run_capture(2, -1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
